// File: rtl/writeback_pkg.sv
// Shared register indices, CPSR flag positions and the writeback queue entry layout.
package writeback_pkg;

  localparam logic [4:0] REG_SP   = 5'd13;
  localparam logic [4:0] REG_PC   = 5'd15;
  localparam logic [4:0] REG_CPSR = 5'd16;

  // NZCV occupies the top nibble of the CPSR.
  localparam int CPSR_N_BIT = 15;
  localparam int CPSR_Z_BIT = 14;
  localparam int CPSR_C_BIT = 13;
  localparam int CPSR_V_BIT = 12;

  localparam int RESULT_W = 16;
  localparam int NZCV_W   = 4;
  localparam int IDX_W    = 5;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic [NZCV_W-1:0]   nzcv;
    logic                flags_en;
    logic [IDX_W-1:0]    dst;
    logic                has_wb;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order FIFO of completed results; also exposes every entry in age order
// (index 0 = head) so the forwarding search can see all pending results.
module wb_queue
  import writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t [DEPTH-1:0] age_entries,
  output logic [DEPTH-1:0]      age_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] slot;
      assign slot            = rd_ptr_reg + PTR_W'(gi);
      assign age_entries[gi] = mem_reg[slot];
      assign age_valid[gi]   = (count_reg > CNT_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: queues execute results, retires them in order to the
// shared register-file port or the CPSR, and forwards pending results.
module writeback
  import writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_wb_valid,
  output logic        ex_wb_ready,
  input  logic [15:0] ex_wb_result,
  input  logic [3:0]  ex_wb_nzcv,
  input  logic        ex_wb_flags_en,
  input  logic [4:0]  ex_wb_reg_idx_dst,
  input  logic        ex_wb_has_writeback,
  output logic        rf_w_en,
  output logic [4:0]  rf_w_idx,
  output logic [15:0] rf_w_data,
  input  logic        rf_w_grant,
  output logic [15:0] cpsr,
  input  logic [4:0]  fwd_q_idx,
  output logic        fwd_hit,
  output logic [15:0] fwd_data,
  output logic        busy
);

  wb_entry_t             push_entry;
  wb_entry_t [DEPTH-1:0] age_entries;
  logic [DEPTH-1:0]      age_valid;
  wb_entry_t             head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  head_is_rf;
  logic                  head_is_cpsr;
  logic [15:0]           cpsr_reg;

  assign push_entry = '{result:   ex_wb_result,
                        nzcv:     ex_wb_nzcv,
                        flags_en: ex_wb_flags_en,
                        dst:      ex_wb_reg_idx_dst,
                        has_wb:   ex_wb_has_writeback};

  assign ex_wb_ready = !full;
  assign push        = ex_wb_valid && !full;
  assign busy        = !empty;

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .age_entries (age_entries),
    .age_valid   (age_valid)
  );

  assign head         = age_entries[0];
  assign head_is_rf   = !empty && head.has_wb && (head.dst != REG_CPSR);
  assign head_is_cpsr = !empty && head.has_wb && (head.dst == REG_CPSR);

  // Only RF-writes wait for the shared port; everything else retires at once.
  assign pop       = !empty && (head_is_rf ? rf_w_grant : 1'b1);
  assign rf_w_en   = head_is_rf;
  assign rf_w_idx  = head_is_rf ? head.dst : 5'd0;
  assign rf_w_data = head_is_rf ? head.result : 16'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpsr_reg <= '0;
    end else if (pop) begin
      if (head_is_cpsr) begin
        cpsr_reg <= head.result;
      end else if (head.flags_en) begin
        cpsr_reg[CPSR_N_BIT:CPSR_V_BIT] <= head.nzcv;
      end
    end
  end

  assign cpsr = cpsr_reg;

  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && age_entries[i].has_wb && age_entries[i].dst == fwd_q_idx) begin
        fwd_hit  = 1'b1;
        fwd_data = age_entries[i].result;
      end
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: accepted RF-writes are queued as expected
// retires and matched against granted register-file writes.
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_wb_valid;
  logic        ex_wb_ready;
  logic [15:0] ex_wb_result;
  logic [3:0]  ex_wb_nzcv;
  logic        ex_wb_flags_en;
  logic [4:0]  ex_wb_reg_idx_dst;
  logic        ex_wb_has_writeback;
  logic        rf_w_en;
  logic [4:0]  rf_w_idx;
  logic [15:0] rf_w_data;
  logic        rf_w_grant;
  logic [15:0] cpsr;
  logic [4:0]  fwd_q_idx;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic        busy;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [20:0] sb_q[$];
  logic        acc;

  always #5 clk = ~clk;

  writeback #(.DEPTH(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ex_wb_valid         (ex_wb_valid),
    .ex_wb_ready         (ex_wb_ready),
    .ex_wb_result        (ex_wb_result),
    .ex_wb_nzcv          (ex_wb_nzcv),
    .ex_wb_flags_en      (ex_wb_flags_en),
    .ex_wb_reg_idx_dst   (ex_wb_reg_idx_dst),
    .ex_wb_has_writeback (ex_wb_has_writeback),
    .rf_w_en             (rf_w_en),
    .rf_w_idx            (rf_w_idx),
    .rf_w_data           (rf_w_data),
    .rf_w_grant          (rf_w_grant),
    .cpsr                (cpsr),
    .fwd_q_idx           (fwd_q_idx),
    .fwd_hit             (fwd_hit),
    .fwd_data            (fwd_data),
    .busy                (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one entry starting just after a rising edge; returns whether it
  // was accepted. Accepted RF-writes become expected retires.
  task automatic send(input logic [4:0] dst, input logic [15:0] res, input logic has_wb,
                      input logic flags_en, input logic [3:0] nzcv, output logic accepted);
    ex_wb_valid         = 1'b1;
    ex_wb_reg_idx_dst   = dst;
    ex_wb_result        = res;
    ex_wb_has_writeback = has_wb;
    ex_wb_flags_en      = flags_en;
    ex_wb_nzcv          = nzcv;
    @(negedge clk);
    accepted = ex_wb_ready;
    if (accepted && has_wb && dst != 5'd16) sb_q.push_back({dst, res});
    $display("push dst=%0d res=%h has_wb=%0b flags_en=%0b nzcv=%b accepted=%0b",
             dst, res, has_wb, flags_en, nzcv, accepted);
    @(posedge clk);
    #1;
    ex_wb_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Every granted request retires at the next edge; compare with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rf_w_en && rf_w_grant) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_write", {27'd0, rf_w_idx}, 32'h1f);
      end else begin
        logic [20:0] e;
        e = sb_q.pop_front();
        $display("retire idx=%0d data=%h exp_idx=%0d exp_data=%h", rf_w_idx, rf_w_data, e[20:16], e[15:0]);
        chk("sb_idx", {27'd0, rf_w_idx}, {27'd0, e[20:16]});
        chk("sb_data", {16'd0, rf_w_data}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    reset = 1'b1;
    ex_wb_valid = 1'b0;
    ex_wb_result = '0;
    ex_wb_nzcv = '0;
    ex_wb_flags_en = 1'b0;
    ex_wb_reg_idx_dst = '0;
    ex_wb_has_writeback = 1'b0;
    rf_w_grant = 1'b0;
    fwd_q_idx = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ex_wb_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rf_en", {31'd0, rf_w_en}, 32'd0);
    chk("rst_cpsr", {16'd0, cpsr}, 32'd0);
    chk("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    next_cycle();

    // Grant high: single RF write.
    rf_w_grant = 1'b1;
    send(5'd3, 16'h1234, 1'b1, 1'b0, 4'd0, acc);
    chk("gh_accept", {31'd0, acc}, 32'd1);
    @(negedge clk);
    chk("gh_rf_en", {31'd0, rf_w_en}, 32'd1);
    chk("gh_idx", {27'd0, rf_w_idx}, 32'd3);
    chk("gh_data", {16'd0, rf_w_data}, 32'h1234);
    next_cycle();
    @(negedge clk);
    chk("gh_busy_drop", {31'd0, busy}, 32'd0);
    chk("gh_idle_idx", {27'd0, rf_w_idx}, 32'd0);
    next_cycle();

    // Grant low: fill the queue, third push refused, head held.
    rf_w_grant = 1'b0;
    send(5'd1, 16'h1111, 1'b1, 1'b0, 4'd0, acc);
    send(5'd2, 16'h2222, 1'b1, 1'b0, 4'd0, acc);
    @(negedge clk);
    chk("gl_ready_full", {31'd0, ex_wb_ready}, 32'd0);
    chk("gl_head_idx", {27'd0, rf_w_idx}, 32'd1);
    next_cycle();
    send(5'd4, 16'h4444, 1'b1, 1'b0, 4'd0, acc);
    chk("gl_third_refused", {31'd0, acc}, 32'd0);
    @(negedge clk);
    chk("gl_head_stable", {16'd0, rf_w_data}, 32'h1111);
    next_cycle();
    rf_w_grant = 1'b1;
    @(negedge clk);
    chk("gl_ready_during_pop", {31'd0, ex_wb_ready}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("gl_second_idx", {27'd0, rf_w_idx}, 32'd2);
    next_cycle();
    @(negedge clk);
    chk("gl_drained", {31'd0, busy}, 32'd0);
    next_cycle();

    // CPSR write with grant low.
    rf_w_grant = 1'b0;
    send(5'd16, 16'hA000, 1'b1, 1'b1, 4'b0001, acc);
    @(negedge clk);
    chk("cp_no_rf_en", {31'd0, rf_w_en}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("cp_value", {16'd0, cpsr}, 32'hA000);
    next_cycle();

    // Flags-only update.
    send(5'd7, 16'hFFFF, 1'b0, 1'b1, 4'b0100, acc);
    @(negedge clk);
    chk("fl_no_rf_en", {31'd0, rf_w_en}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("fl_cpsr", {16'd0, cpsr}, 32'h4000);
    next_cycle();

    // Forwarding: youngest match wins.
    send(5'd5, 16'd1, 1'b1, 1'b0, 4'd0, acc);
    send(5'd5, 16'd2, 1'b1, 1'b0, 4'd0, acc);
    fwd_q_idx = 5'd5;
    @(negedge clk);
    chk("fw_hit", {31'd0, fwd_hit}, 32'd1);
    chk("fw_youngest", {16'd0, fwd_data}, 32'd2);
    next_cycle();
    fwd_q_idx = 5'd7;
    @(negedge clk);
    chk("fw_miss_hit", {31'd0, fwd_hit}, 32'd0);
    chk("fw_miss_data", {16'd0, fwd_data}, 32'd0);
    next_cycle();
    fwd_q_idx = 5'd5;
    rf_w_grant = 1'b1;
    next_cycle();
    rf_w_grant = 1'b0;
    @(negedge clk);
    chk("fw_after_retire_hit", {31'd0, fwd_hit}, 32'd1);
    chk("fw_after_retire_data", {16'd0, fwd_data}, 32'd2);
    next_cycle();

    // Reset with pending entries and grant high.
    send(5'd6, 16'h6666, 1'b1, 1'b0, 4'd0, acc);
    rf_w_grant = 1'b1;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_cpsr", {16'd0, cpsr}, 32'd0);
    chk("rs_rf_en", {31'd0, rf_w_en}, 32'd0);
    chk("rs_ready", {31'd0, ex_wb_ready}, 32'd1);
    chk("rs_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    next_cycle();

    // Back-to-back pushes with grant held: every expectation must drain.
    for (int i = 0; i < 4; i++) begin
      send(5'(8 + i), 16'(16'hC000 + i), 1'b1, 1'b0, 4'd0, acc);
      chk("bb_accept", {31'd0, acc}, 32'd1);
    end
    repeat (4) next_cycle();
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("bb_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
